amb_p: RTL



---
 rtl/amb_p_if.sv | 16 +
 rtl/amb_p.sv | 70 +++++++
 2 files changed

// File: rtl/amb_p_if.sv
// amb_p_if: instruction/data memory bus of the amb_p accumulator core.
interface amb_p_if #(parameter int DATA_W = 16, parameter int ADDR_W = 8, parameter int OPCODE_W = 4);
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ddatain;
  logic [DATA_W-1:0] accum;
  logic dready;
  logic dreq;
  logic we;
  logic zf;
  logic cf;
  logic halt;
  modport master (input opcode, operand, ddatain, dready, output pc, accum, dreq, we, zf, cf, halt);
  modport slave (output opcode, operand, ddatain, dready, input pc, accum, dreq, we, zf, cf, halt);
endinterface

// File: rtl/amb_p.sv
// amb_p: multicycle accumulator core with carry/zero flags, branches, immediates,
// halt and a data-memory request/ready handshake that tolerates wait states.
module amb_p #(parameter int DATA_W = 16, parameter int ADDR_W = 8, parameter int OPCODE_W = 4) (
  input logic clk,
  input logic rst_n,
  amb_p_if.master bus
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, HALT} state_t;
  state_t state, state_n;
  logic [3:0] lat_op, op;
  logic [ADDR_W-1:0] lat_opr, opr, pc_n;
  logic [DATA_W-1:0] din, imm;
  logic [DATA_W:0] res;
  logic mem_op, done, wr_acc, taken;
  always_comb begin
    // opcodes with any bit above bit 3 set decode as NOP
    op = state == WAIT ? lat_op : ((bus.opcode >> 4) == '0) ? bus.opcode[3:0] : 4'h0;
    opr = state == WAIT ? lat_opr : bus.operand;
    din = bus.ddatain;
    imm = DATA_W'(opr);
    mem_op = op inside {[4'h1:4'h7]};
    bus.dreq = rst_n && (state == WAIT || (state == EXEC && mem_op));
    bus.we = bus.dreq && op == 4'h2;
    done = (state == EXEC && (!mem_op || bus.dready)) || (state == WAIT && bus.dready);
    taken = op == 4'hA || (op == 4'hB && bus.zf) || (op == 4'hC && !bus.zf) || (op == 4'hD && bus.cf);
    wr_acc = 1'b1;
    // res carries the next cf in its top bit; ops that leave cf alone pass it through
    case (op)
      4'h1: res = {bus.cf, din};
      4'h3: res = {1'b0, bus.accum} + {1'b0, din};
      4'h4: res = {din > bus.accum, bus.accum - din};
      4'h5: res = {bus.cf, bus.accum & din};
      4'h6: res = {bus.cf, bus.accum | din};
      4'h7: res = {bus.cf, bus.accum ^ din};
      4'h8: res = {bus.cf, imm};
      4'h9: res = {1'b0, bus.accum} + {1'b0, imm};
      4'hE: res = {bus.accum[0], bus.accum >> 1};
      default: begin
        res = {bus.cf, bus.accum};
        wr_acc = 1'b0;
      end
    endcase
    state_n = state == IDLE ? EXEC : state == HALT ? HALT : !done ? WAIT : op == 4'hF ? HALT : EXEC;
    pc_n = (!done || op == 4'hF) ? bus.pc : taken ? opr : bus.pc + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.pc <= '0;
      bus.accum <= '0;
      bus.zf <= 1'b1;
      bus.cf <= 1'b0;
      lat_op <= '0;
      lat_opr <= '0;
    end else begin
      state <= state_n;
      bus.pc <= pc_n;
      if (done && wr_acc) begin
        bus.accum <= res[DATA_W-1:0];
        bus.zf <= res[DATA_W-1:0] == '0;
      end
      if (done) bus.cf <= res[DATA_W];
      if (state == EXEC) begin
        lat_op <= op;
        lat_opr <= opr;
      end
    end
  end
  assign bus.halt = state == HALT;
endmodule
